pipe_reg_chain: RTL
===================

Name: pipe_reg_chain

Overview:
- Parametrised chain of inter-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB generalised to STAGES).
- Replaces hand-written per-stage register modules and their separate per-stage resets.
- Each stage has a valid bit, per-stage stall and flush, and automatic bubble insertion.
- Carries performance counters (retired, bubbles, front-end stall cycles) for CPU bring-up.

Parameters:
- DATA_W, 32, width of the payload carried by each stage register.
- STAGES, 4, number of stage registers; stage 0 is first (IF/ID), stage STAGES-1 is last (MEM/WB). Minimum 1.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream (fetch) presents a valid payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  chain will capture in_data at this edge; equals !hold[0].
- stall  in  STAGES  stall[i] freezes stage i and every stage upstream of it.
- flush  in  STAGES  flush[i] invalidates the contents of stage i at this edge.
- clr_cnt  in  1  synchronous clear of all counters.
- stage_valid  out  STAGES  valid bit of each stage register.
- stage_data  out  STAGES*DATA_W  payload of each stage; stage i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  equals stage_valid[STAGES-1].
- out_data  out  DATA_W  payload of stage STAGES-1.
- retired_cnt  out  CNT_W  count of instructions leaving the last stage.
- bubble_cnt  out  CNT_W  count of stall-induced bubbles.
- stall_cycles  out  CNT_W  count of cycles with in_ready=0.

Behaviour:
- Reset: at an edge with reset=1, every stage_valid=0, every stage_data=0, all counters=0; reset overrides all other inputs. in_ready is combinational, so with reset held it still reflects the stall inputs.
- Hold: hold[i] = OR of stall[j] for j = i..STAGES-1, so a downstream stall freezes all upstream stages.
- Source of stage i: in_valid/in_data for i=0, otherwise the current contents of stage i-1.
- Per-edge update of stage i, in priority order:
  1. reset.
  2. flush[i]=1: valid<=0, data unchanged. This applies even if held.
  3. hold[i]=1: hold valid and data.
  4. i>0 and hold[i-1]=1 and hold[i]=0: bubble; valid<=0, data unchanged.
  5. Otherwise load the source. For stage 0, valid<=in_valid and data<=in_data.
- Flushing stage i does not prevent stage i+1 from loading stage i's pre-edge contents at the same edge.
- Latency: a payload accepted at edge k is in stage i after edge k+i, and on out_* after edge k+STAGES-1. There is no combinational in->out path.
- Throughput: 1 payload per cycle when there is no stall or flush.
- retired_cnt increments by 1 when out_valid=1, stall[STAGES-1]=0 and flush[STAGES-1]=0.
- bubble_cnt increments by the number of stages taking rule 4 at this edge, so several stages may contribute in one edge.
- stall_cycles increments when hold[0]=1.
- Counters wrap modulo 2^CNT_W. clr_cnt=1 zeroes the counters at the edge and suppresses that edge's increments. reset dominates clr_cnt.
- Reset asserted mid-stream discards all in-flight payloads; nothing is retired on the reset edge.
- STAGES=1: there is no rule 4, and bubble_cnt stays 0.

Decomposition:
- Shared package pipe_pkg:
  - stage index constants IF_ID=0, ID_EXE=1, EXE_MEM=2, MEM_WB=3;
  - default DATA_W and CNT_W localparams;
  - popcount function used for bubble_cnt.
- Sub-module pipe_stage_reg: one valid+data register implementing rules 1-5 from inputs reset, flush, hold, bubble, src_valid, src_data. It is instantiated STAGES times via a generate loop.
- Counters and the hold chain live in the top module.

Test Plan:
- Streaming: reset 2 cycles, then in_valid=1 with in_data 0x10, 0x11, 0x12, 0x13 on consecutive edges -> out_data 0x10 first visible after the 4th edge, then 0x11-0x13 back-to-back; retired_cnt reaches 4; bubble_cnt and stall_cycles remain 0.
- Load-use stall: with the chain full, stall[1]=1 for one cycle -> stages 0 and 1 hold; stage 2 goes invalid; in_ready=0 that cycle; bubble_cnt=1 and stall_cycles=1; the sequence resumes with no lost or duplicated payloads.
- Branch flush: flush[0]=flush[1]=1 for one cycle with stages holding 0x21 and 0x20 -> both invalid after the edge; 0x20 and 0x21 never appear on out_data; retired_cnt is unchanged for the two corresponding slots.
- Simultaneous flush and stall: flush[1]=1 and stall[1]=1 in the same cycle -> stage 1 is invalid; stage 0 holds; stage 2 takes a bubble; bubble_cnt increments by 1.
- Reset mid-operation: reset=1 for one edge with all 4 stages valid -> stage_valid=4'b0000, out_data=0, all counters 0; the next accepted payload 0x40 exits after the 4th edge.
- Counter wrap with CNT_W=4: stream 17 payloads with no stalls -> retired_cnt reads 15 then 0 then 1; clr_cnt=1 on a retiring edge -> retired_cnt=0, not 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
// Stage indices name the classic five-stage boundaries.
package pipe_pkg;

  localparam int IF_ID   = 0;
  localparam int ID_EXE  = 1;
  localparam int EXE_MEM = 2;
  localparam int MEM_WB  = 3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 32;
  localparam int MAX_STAGES = 64;

  function automatic logic [6:0] popcount(
    input logic [MAX_STAGES-1:0] v
  );
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid+payload stage register: reset, flush, hold, bubble, load.
// Flush only clears valid; payload bits are left as they were.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        valid <= 1'b0;
      end else begin
        valid <= src_valid;
        data  <= src_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised chain of inter-stage pipeline registers with
// stall/flush/bubble control and bring-up performance counters.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int STAGES = 4,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  input  logic                     clr_cnt,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         retired_cnt,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         stall_cycles
);

  logic [STAGES-1:0]     hold;
  logic [STAGES-1:0]     bub_cond;
  logic [STAGES-1:0]     bub_take;
  logic [MAX_STAGES-1:0] bub_vec;
  logic [DATA_W-1:0]     data_q [STAGES];
  logic                  retire;

  // A stall anywhere downstream freezes every stage above it.
  always_comb begin
    hold = '0;
    bub_cond = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
    for (int i = 1; i < STAGES; i++) begin
      bub_cond[i] = hold[i-1] & ~hold[i];
    end
  end

  assign bub_take = bub_cond & ~flush;
  assign bub_vec  = MAX_STAGES'(bub_take);
  assign in_ready = ~hold[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = stage_valid[i-1];
      assign src_data  = data_q[i-1];
    end
    pipe_stage_reg #(
      .DATA_W(DATA_W)
    ) u_reg (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush[i]),
      .hold     (hold[i]),
      .bubble   (bub_cond[i]),
      .src_valid(src_valid),
      .src_data (src_data),
      .valid    (stage_valid[i]),
      .data     (data_q[i])
    );
    assign stage_data[i*DATA_W +: DATA_W] = data_q[i];
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign retire    = out_valid & ~stall[STAGES-1]
                   & ~flush[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      retired_cnt  <= '0;
      bubble_cnt   <= '0;
      stall_cycles <= '0;
    end else begin
      retired_cnt  <= retired_cnt + CNT_W'(retire);
      bubble_cnt   <= bubble_cnt
                    + CNT_W'(popcount(bub_vec));
      stall_cycles <= stall_cycles + CNT_W'(hold[0]);
    end
  end

endmodule
